arilogcal_param: RTL and testbench

ARILOGCAL_PARAM -- requirements
Module: arilogcal_param

---
 rtl/arilogcal_pkg.sv | 55 +++++
 rtl/bcd_seq.sv | 71 +++++++
 rtl/arilogcal_param.sv | 187 ++++++++++++++++++
 tb/tb_arilogcal_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arilogcal_pkg.sv
// Shared types, seven-segment glyphs and a combinational binary-to-BCD helper
// for the arithmetic/logic calculator.
package arilogcal_pkg;

  typedef enum logic [2:0] {
    OpInvalid = 3'd0,
    OpAdd     = 3'd1,
    OpMul     = 3'd2,
    OpDiv     = 3'd3,
    OpAnd     = 3'd4,
    OpOr      = 3'd5,
    OpSub     = 3'd6,
    OpMod     = 3'd7
  } op_e;

  typedef enum logic {
    StIdle    = 1'b0,
    StConvert = 1'b1
  } state_e;

  // Active-low segments, bit7 is the decimal point and stays dark.
  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegMinus = 8'hBF;
  localparam logic [7:0] SegE     = 8'h86;
  localparam logic [7:0] SegR     = 8'hAF;

  localparam logic [9:0][7:0] SegDigits = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
    logic [7:0] glyph;
    glyph = SegBlank;
    if (digit <= 4'd9) begin
      glyph = SegDigits[digit];
    end
    return glyph;
  endfunction

  // Covers any operand up to 16 bits (five decimal digits).
  function automatic logic [19:0] to_bcd(input logic [15:0] value);
    logic [19:0] bcd;
    bcd = '0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[18:0], value[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bcd_seq.sv
// Sequential double-dabble converter: one source bit per cycle, plus one
// closing cycle in which done_o flags that bcd_o holds the final digits.
module bcd_seq #(
  parameter int unsigned ValueWidth = 16,
  parameter int unsigned Digits     = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ValueWidth-1:0]   value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*Digits-1:0]     bcd_o
);

  localparam int unsigned CntW = $clog2(ValueWidth + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ValueWidth);

  logic [ValueWidth-1:0] shift_q, shift_d;
  logic [4*Digits-1:0]   bcd_q, bcd_d, adj;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < int'(Digits); d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end

    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;

    if (start_i && !busy_q) begin
      shift_d = value_i;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
      end else begin
        bcd_d   = {adj[4*Digits-2:0], shift_q[ValueWidth-1]};
        shift_d = {shift_q[ValueWidth-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LastCnt);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/arilogcal_param.sv
// Calculator with seven-segment operand/result displays; the result is
// computed on an equals-key release and converted to decimal serially.
module arilogcal_param
  import arilogcal_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OPD_DIGITS = 3,
  parameter int unsigned RES_DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        ac,
  input  logic [WIDTH-1:0]            opt_a,
  input  logic [WIDTH-1:0]            opt_b,
  input  logic [2:0]                  do_opt,
  input  logic                        equal_to,
  output logic                        busy,
  output logic                        err,
  output logic [OPD_DIGITS-1:0][7:0]  seg_a,
  output logic [OPD_DIGITS-1:0][7:0]  seg_b,
  output logic [7:0]                  seg_op,
  output logic [RES_DIGITS-1:0][7:0]  seg_res
);

  localparam int unsigned ResW = 2 * WIDTH;

  state_e                       state_q, state_d;
  logic [WIDTH-1:0]             a_q, a_d, b_q, b_d;
  op_e                          opt_q, opt_d;
  logic                         sign_q, sign_d;
  logic                         eq_q;
  logic                         err_q, err_d;
  logic [RES_DIGITS-1:0][7:0]   seg_res_q, seg_res_d;

  logic [ResW-1:0]              aw, bw, calc_val;
  logic                         calc_neg, calc_err;
  logic                         trigger, start;
  logic                         seq_busy, seq_done;
  logic [4*RES_DIGITS-1:0]      seq_bcd;
  logic [RES_DIGITS-1:0][7:0]   res_fmt, res_err;
  int                           msd;

  // Operands are taken straight from the inputs: they are what a/b/opt latch
  // on the trigger edge and then hold for the whole conversion.
  always_comb begin
    aw       = ResW'(opt_a);
    bw       = ResW'(opt_b);
    calc_val = '0;
    calc_neg = 1'b0;
    calc_err = 1'b0;
    case (op_e'(do_opt))
      OpAdd: calc_val = aw + bw;
      OpMul: calc_val = aw * bw;
      OpDiv: begin
        if (bw == '0) calc_err = 1'b1;
        else          calc_val = aw / bw;
      end
      OpAnd: calc_val = {{(ResW-1){1'b0}}, (|opt_a) & (|opt_b)};
      OpOr:  calc_val = {{(ResW-1){1'b0}}, (|opt_a) | (|opt_b)};
      OpSub: begin
        if (aw < bw) begin
          calc_val = bw - aw;
          calc_neg = 1'b1;
        end else begin
          calc_val = aw - bw;
        end
      end
      OpMod: begin
        if (bw == '0) calc_err = 1'b1;
        else          calc_val = aw % bw;
      end
      default: calc_err = 1'b1;
    endcase
  end

  assign trigger = (state_q == StIdle) && eq_q && !equal_to;
  assign start   = trigger && !calc_err;

  bcd_seq #(
    .ValueWidth (ResW),
    .Digits     (RES_DIGITS)
  ) u_bcd_seq (
    .clk_i   (clk),
    .rst_i   (ac),
    .start_i (start),
    .value_i (calc_val),
    .busy_o  (seq_busy),
    .done_o  (seq_done),
    .bcd_o   (seq_bcd)
  );

  // Leading-zero blanking; digit 0 is always lit so a zero shows as "0".
  always_comb begin
    msd = 0;
    for (int i = 0; i < int'(RES_DIGITS); i++) begin
      if (seq_bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < int'(RES_DIGITS); i++) begin
      res_fmt[i] = (i <= msd) ? seg_glyph(seq_bcd[4*i +: 4]) : SegBlank;
    end
    if (sign_q && ((msd + 1) < int'(RES_DIGITS))) begin
      res_fmt[msd+1] = SegMinus;
    end
  end

  always_comb begin
    res_err    = {RES_DIGITS{SegBlank}};
    res_err[2] = SegE;
    res_err[1] = SegR;
    res_err[0] = SegR;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    opt_d     = opt_q;
    sign_d    = sign_q;
    err_d     = err_q;
    seg_res_d = seg_res_q;
    unique case (state_q)
      StIdle: begin
        a_d   = opt_a;
        b_d   = opt_b;
        opt_d = op_e'(do_opt);
        if (trigger) begin
          if (calc_err) begin
            err_d     = 1'b1;
            seg_res_d = res_err;
          end else begin
            state_d = StConvert;
            sign_d  = calc_neg;
          end
        end
      end
      StConvert: begin
        if (seq_done) begin
          state_d   = StIdle;
          err_d     = 1'b0;
          seg_res_d = res_fmt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ac) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      opt_q     <= OpInvalid;
      sign_q    <= 1'b0;
      eq_q      <= 1'b0;
      err_q     <= 1'b0;
      seg_res_q <= {RES_DIGITS{SegBlank}};
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opt_q     <= opt_d;
      sign_q    <= sign_d;
      eq_q      <= equal_to;
      err_q     <= err_d;
      seg_res_q <= seg_res_d;
    end
  end

  logic [19:0] a_bcd, b_bcd;
  assign a_bcd = to_bcd(16'(a_q));
  assign b_bcd = to_bcd(16'(b_q));

  for (genvar i = 0; i < OPD_DIGITS; i++) begin : g_opd
    if (i < 5) begin : g_dig
      assign seg_a[i] = seg_glyph(a_bcd[4*i +: 4]);
      assign seg_b[i] = seg_glyph(b_bcd[4*i +: 4]);
    end else begin : g_pad
      assign seg_a[i] = SegDigits[0];
      assign seg_b[i] = SegDigits[0];
    end
  end

  assign seg_op  = seg_glyph({1'b0, opt_q});
  assign seg_res = seg_res_q;
  assign err     = err_q;
  assign busy    = seq_busy;

endmodule

// File: tb/tb_arilogcal_param.sv
// Directed bench for arilogcal_param (WIDTH=8) against a cycle-level model of
// the calculator's externally visible behaviour, plus literal display checks.
module tb_arilogcal_param;

  localparam int W  = 8;
  localparam int OD = 3;
  localparam int RD = 5;
  localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic              clk = 1'b0;
  logic              ac = 1'b1;
  logic [W-1:0]      opt_a = '0, opt_b = '0;
  logic [2:0]        do_opt = '0;
  logic              equal_to = 1'b0;
  logic              busy, err;
  logic [OD-1:0][7:0] seg_a, seg_b;
  logic [7:0]        seg_op;
  logic [RD-1:0][7:0] seg_res;

  int total = 0;
  int bad = 0;

  arilogcal_param #(.WIDTH(W), .OPD_DIGITS(OD), .RES_DIGITS(RD)) dut (
    .clk      (clk),
    .ac       (ac),
    .opt_a    (opt_a),
    .opt_b    (opt_b),
    .do_opt   (do_opt),
    .equal_to (equal_to),
    .busy     (busy),
    .err      (err),
    .seg_a    (seg_a),
    .seg_b    (seg_b),
    .seg_op   (seg_op),
    .seg_res  (seg_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [8*RD-1:0] render(input longint v, input bit neg);
    logic [8*RD-1:0] r;
    int i;
    r = '1;
    i = 0;
    if (v == 0) begin
      r[7:0] = GLYPH[0];
      i = 1;
    end
    while (v > 0 && i < RD) begin
      r[8*i +: 8] = GLYPH[int'(v % 10)];
      v = v / 10;
      i++;
    end
    if (neg && i < RD) r[8*i +: 8] = 8'hBF;
    return r;
  endfunction

  function automatic logic [8*OD-1:0] opd(input int v);
    logic [8*OD-1:0] r;
    for (int i = 0; i < OD; i++) begin
      r[8*i +: 8] = GLYPH[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void calc(input int a, input int b, input int op,
                               output longint v, output bit neg, output bit e);
    v = 0; neg = 0; e = 0;
    case (op)
      1: v = a + b;
      2: v = longint'(a) * b;
      3: if (b == 0) e = 1; else v = a / b;
      4: v = (a != 0 && b != 0) ? 1 : 0;
      5: v = (a != 0 || b != 0) ? 1 : 0;
      6: begin v = a - b; if (v < 0) begin neg = 1; v = -v; end end
      7: if (b == 0) e = 1; else v = a % b;
      default: e = 1;
    endcase
  endfunction

  // Behavioural model: a countdown stands in for the conversion.
  int m_a, m_b, m_op, m_cnt;
  bit m_err, m_eqprev, m_valid;
  logic [8*RD-1:0] m_res, m_pend;

  always @(posedge clk) begin
    longint v;
    bit neg, e, trig;
    if (ac) begin
      m_valid = 1; m_cnt = 0; m_a = 0; m_b = 0; m_op = 0;
      m_err = 0; m_eqprev = 0; m_res = '1;
    end else if (m_valid) begin
      trig = (m_cnt == 0) && m_eqprev && !equal_to;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_res = m_pend;
          m_err = 0;
        end
      end else begin
        m_a = int'(opt_a); m_b = int'(opt_b); m_op = int'(do_opt);
        if (trig) begin
          calc(m_a, m_b, m_op, v, neg, e);
          if (e) begin
            m_err = 1;
            m_res = {8'hFF, 8'hFF, 8'h86, 8'hAF, 8'hAF};
          end else begin
            m_pend = render(v, neg);
            m_cnt = 2 * W + 1;
          end
        end
      end
      m_eqprev = equal_to;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_cnt != 0);
      chk("err", err, m_err);
      chk("seg_res", seg_res, m_res);
      chk("seg_a", seg_a, opd(m_a));
      chk("seg_b", seg_b, opd(m_b));
      chk("seg_op", seg_op, GLYPH[m_op]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sets operands, releases the equals key, returns the busy length seen.
  task automatic run_op(input int a, input int b, input int op, output int n);
    opt_a = W'(a); opt_b = W'(b); do_opt = 3'(op);
    cyc(2);
    equal_to = 1'b1;
    cyc(1);
    equal_to = 1'b0;
    cyc(1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      cyc(1);
    end
  endtask

  initial begin
    int n;
    cyc(1);
    chk("rst_res", seg_res, 40'hFFFFFFFFFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_seg_a", seg_a, 24'hC0C0C0);
    chk("rst_seg_op", seg_op, 8'hC0);
    ac = 1'b0;
    cyc(2);

    run_op(200, 250, 2, n);
    chk("mul_len", n, 17);
    chk("mul_res", seg_res, 40'h92C0C0C0C0);
    chk("mul_err", err, 1'b0);

    run_op(3, 0, 3, n);
    chk("div0_len", n, 0);
    chk("div0_res", seg_res, 40'hFFFF86AFAF);
    chk("div0_err", err, 1'b1);

    run_op(3, 0, 7, n);
    chk("mod0_len", n, 0);
    chk("mod0_err", err, 1'b1);

    run_op(5, 9, 6, n);
    chk("sub_neg", seg_res, 40'hFFFFFFBF99);
    run_op(9, 5, 6, n);
    chk("sub_pos", seg_res, 40'hFFFFFFFF99);

    run_op(17, 5, 7, n);
    chk("mod", seg_res, 40'hFFFFFFFFA4);
    run_op(12, 0, 4, n);
    chk("and0", seg_res, 40'hFFFFFFFFC0);

    run_op(255, 255, 1, n);
    run_op(255, 255, 2, n);
    run_op(0, 0, 0, n);
    chk("inv_len", n, 0);
    run_op(7, 0, 5, n);

    // Second key press and operand change while converting.
    opt_a = 8'd100; opt_b = 8'd23; do_opt = 3'd1;
    cyc(2);
    equal_to = 1'b1;
    cyc(1);
    equal_to = 1'b0;
    cyc(3);
    equal_to = 1'b1;
    opt_a = 8'd77;
    cyc(1);
    equal_to = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      cyc(1);
    end
    chk("retrig_res", seg_res, 40'hFFFFF9A4B0);
    cyc(5);
    chk("retrig_idle", busy, 1'b0);

    opt_a = 8'd40; opt_b = 8'd40; do_opt = 3'd2;
    cyc(2);
    equal_to = 1'b1;
    cyc(1);
    equal_to = 1'b0;
    cyc(5);
    ac = 1'b1;
    cyc(1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_res", seg_res, 40'hFFFFFFFFFF);
    ac = 1'b0;
    cyc(20);
    chk("abort_quiet", busy, 1'b0);
    chk("abort_res2", seg_res, 40'hFFFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
